// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator step controller slice.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DOOR
    } state_e;

    localparam int unsigned DEF_NUM_FLOORS = 4;
    localparam int unsigned DEF_DOOR_TICKS = 2;

    // Width of a floor index for n floors (at least one bit).
    function automatic int unsigned floor_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/elevator_step_ctrl_if.sv
// Slow-tick / car-status bundle between the divider side and the step controller.
// Optional macro ELEVATOR_DOOR_HOLD_EN adds the door_hold input.
interface elevator_step_ctrl_if
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = DEF_NUM_FLOORS
) ();

    localparam int unsigned FLOOR_W = floor_w(NUM_FLOORS);

    logic                  tick_in;
    logic [NUM_FLOORS-1:0] req;
`ifdef ELEVATOR_DOOR_HOLD_EN
    logic                  door_hold;
`endif
    logic                  hold;
    logic [FLOOR_W-1:0]    floor;
    logic                  dir_up;
    logic                  moving;
    logic                  door_open;
    logic [NUM_FLOORS-1:0] pending;

    // Divider / button side.
    modport master (
`ifdef ELEVATOR_DOOR_HOLD_EN
        output door_hold,
`endif
        output tick_in, req,
        input  hold, floor, dir_up, moving, door_open, pending
    );

    // Controller side.
    modport slave (
`ifdef ELEVATOR_DOOR_HOLD_EN
        input  door_hold,
`endif
        input  tick_in, req,
        output hold, floor, dir_up, moving, door_open, pending
    );

endinterface

// File: rtl/tick_edge_sync.sv
// Three-flop synchroniser for the divider's toggling tick; any edge yields a one-cycle step.
module tick_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic tick_in,
    output logic step
);

    logic s1;
    logic s2;
    logic s3;

    // s1/s2 resolve metastability, s3 holds the previous settled level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tick_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign step = s2 ^ s3;

endmodule

// File: rtl/elevator_step_ctrl.sv
// Single-car elevator controller stepped by the divider's slow tick.
// Optional macro ELEVATOR_DOOR_HOLD_EN: door_hold keeps the door open while asserted.
module elevator_step_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int unsigned DOOR_TICKS = DEF_DOOR_TICKS
) (
    input logic                clk,
    input logic                reset,
    elevator_step_ctrl_if.slave bus
);

    localparam int unsigned FLOOR_W = floor_w(NUM_FLOORS);
    localparam int unsigned CNT_W   = $clog2(DOOR_TICKS + 1);

    state_e                state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic                  dir_up_q, dir_up_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  step;
    logic                  above;
    logic                  below;
    logic                  door_reload;
    logic [FLOOR_W-1:0]    next_floor;

    tick_edge_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .tick_in (bus.tick_in),
        .step    (step)
    );

    // Outstanding work ahead of / behind the car, from registered requests only.
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i]) begin
                if (FLOOR_W'(i) > floor_q) above = 1'b1;
                if (FLOOR_W'(i) < floor_q) below = 1'b1;
            end
        end
    end

    // Door counter reload: a repeat press at the open floor (or door_hold) restarts the dwell.
    always_comb begin
        door_reload = (state_q == DOOR) && bus.req[floor_q];
`ifdef ELEVATOR_DOOR_HOLD_EN
        if ((state_q == DOOR) && bus.door_hold) door_reload = 1'b1;
`endif
    end

    // Next-state, request latch and direction selection.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_up_d   = dir_up_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q | bus.req;
        next_floor = dir_up_q ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));

        // A press at the open floor is absorbed by the door, never latched.
        if (state_q == DOOR) pending_d[floor_q] = pending_q[floor_q];

        unique case (state_q)
            IDLE: begin
                if (pending_q[floor_q]) begin
                    state_d            = DOOR;
                    pending_d[floor_q] = 1'b0;
                    cnt_d              = CNT_W'(DOOR_TICKS);
                end else if (above && (dir_up_q || !below)) begin
                    state_d  = MOVE;
                    dir_up_d = 1'b1;
                end else if (below) begin
                    state_d  = MOVE;
                    dir_up_d = 1'b0;
                end
            end
            MOVE: begin
                if (step) begin
                    floor_d = next_floor;
                    // Uses the old pending: a press arriving with this step is passed by.
                    if (pending_q[next_floor]) begin
                        state_d               = DOOR;
                        pending_d[next_floor] = 1'b0;
                        cnt_d                 = CNT_W'(DOOR_TICKS);
                    end
                end
            end
            DOOR: begin
                if (door_reload) begin
                    cnt_d = CNT_W'(DOOR_TICKS);
                end else if (step) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        if (dir_up_q ? above : below) begin
                            state_d = MOVE;
                        end else if (dir_up_q ? below : above) begin
                            state_d  = MOVE;
                            dir_up_d = !dir_up_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            dir_up_q  <= 1'b1;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_up_q  <= dir_up_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.hold      = (state_q == IDLE);
    assign bus.moving    = (state_q == MOVE);
    assign bus.door_open = (state_q == DOOR);
    assign bus.floor     = floor_q;
    assign bus.dir_up    = dir_up_q;
    assign bus.pending   = pending_q;

endmodule

// File: tb/tb_elevator_step_ctrl.sv
// Directed bench for elevator_step_ctrl with NUM_FLOORS=4, DOOR_TICKS=2.
module tb_elevator_step_ctrl;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    elevator_step_ctrl_if #(.NUM_FLOORS(4)) bus ();

    elevator_step_ctrl #(
        .NUM_FLOORS (4),
        .DOOR_TICKS (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One divider toggle, then wait until its action has registered.
    task automatic tick();
        bus.tick_in = ~bus.tick_in;
        cyc(3);
    endtask

    task automatic pulse_req(input logic [3:0] r);
        bus.req = r;
        cyc(1);
        bus.req = 4'b0000;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_floor"},   32'(bus.floor), 0);
        check({tag, "_hold"},    32'(bus.hold), 1);
        check({tag, "_dir_up"},  32'(bus.dir_up), 1);
        check({tag, "_pending"}, 32'(bus.pending), 0);
        check({tag, "_moving"},  32'(bus.moving), 0);
        check({tag, "_door"},    32'(bus.door_open), 0);
    endtask

    // Floor must always stay inside the building.
    always @(negedge clk) begin
        if (!reset) begin
            total++;
            assert (bus.floor < 3'd4) passed++;
            else $error("FAIL floor_range: observed %0d expected <4", bus.floor);
        end
    end

    initial begin
        reset       = 1'b1;
        bus.tick_in = 1'b0;
        bus.req     = 4'b0000;
`ifdef ELEVATOR_DOOR_HOLD_EN
        bus.door_hold = 1'b0;
`endif
        cyc(3);
        check_reset_vals("rst");
        reset = 1'b0;
        cyc(2);

        // Idle with the tick toggling: nothing may move.
        for (int i = 0; i < 10; i++) begin
            bus.tick_in = ~bus.tick_in;
            cyc(5);
        end
        check("idle_floor", 32'(bus.floor), 0);
        check("idle_hold", 32'(bus.hold), 1);
        check("idle_pending", 32'(bus.pending), 0);
        check("idle_moving", 32'(bus.moving), 0);

        // Floor 0 -> 3.
        pulse_req(4'b1000);
        check("lat_pending", 32'(bus.pending), 32'h8);
        check("lat_hold_still", 32'(bus.hold), 1);
        cyc(1);
        check("go_hold", 32'(bus.hold), 0);
        check("go_moving", 32'(bus.moving), 1);
        check("go_dir", 32'(bus.dir_up), 1);
        bus.tick_in = ~bus.tick_in;
        cyc(2);
        check("lat_k1_floor", 32'(bus.floor), 0);
        cyc(1);
        check("lat_k2_floor", 32'(bus.floor), 1);
        tick();
        check("up_floor2", 32'(bus.floor), 2);
        tick();
        check("up_floor3", 32'(bus.floor), 3);
        check("up_door", 32'(bus.door_open), 1);
        check("up_pending", 32'(bus.pending), 0);
        check("up_moving", 32'(bus.moving), 0);
        tick();
        check("dwell1_door", 32'(bus.door_open), 1);
        tick();
        check("dwell2_door", 32'(bus.door_open), 0);
        check("dwell2_hold", 32'(bus.hold), 1);
        check("dwell2_floor", 32'(bus.floor), 3);

        // Reset while idle at floor 3, then a stray sync edge while idle.
        reset = 1'b1;
        #1;
        check_reset_vals("rst2");
        cyc(1);
        reset = 1'b0;
        cyc(5);
        check("stray_floor", 32'(bus.floor), 0);

        // Park at floor 2 heading up.
        pulse_req(4'b0100);
        cyc(1);
        tick();
        tick();
        check("p2_door", 32'(bus.door_open), 1);
        tick();
        tick();
        check("p2_floor", 32'(bus.floor), 2);
        check("p2_dir", 32'(bus.dir_up), 1);
        check("p2_hold", 32'(bus.hold), 1);

        // Requests above and below: up first, then reverse.
        pulse_req(4'b1001);
        cyc(1);
        check("rev_moving", 32'(bus.moving), 1);
        check("rev_dir_up", 32'(bus.dir_up), 1);
        tick();
        check("rev_floor3", 32'(bus.floor), 3);
        check("rev_door3", 32'(bus.door_open), 1);
        check("rev_pend3", 32'(bus.pending), 32'h1);
        tick();
        tick();
        check("rev_turn_moving", 32'(bus.moving), 1);
        check("rev_turn_dir", 32'(bus.dir_up), 0);
        check("rev_turn_floor", 32'(bus.floor), 3);
        tick();
        check("rev_floor2", 32'(bus.floor), 2);
        tick();
        check("rev_floor1", 32'(bus.floor), 1);
        tick();
        check("rev_floor0", 32'(bus.floor), 0);
        check("rev_door0", 32'(bus.door_open), 1);
        check("rev_pend0", 32'(bus.pending), 0);
        tick();
        tick();
        check("rev_idle_hold", 32'(bus.hold), 1);
        check("rev_idle_dir", 32'(bus.dir_up), 0);

        // Door reload at floor 1.
        pulse_req(4'b0010);
        cyc(1);
        check("rl_dir", 32'(bus.dir_up), 1);
        tick();
        check("rl_floor", 32'(bus.floor), 1);
        check("rl_door", 32'(bus.door_open), 1);
        tick();
        pulse_req(4'b0010);
        check("rl_pending", 32'(bus.pending), 0);
        tick();
        check("rl_still_open", 32'(bus.door_open), 1);
        tick();
        check("rl_closed", 32'(bus.door_open), 0);
        check("rl_hold", 32'(bus.hold), 1);

        // Request on the same cycle as the step reaching that floor is passed.
        pulse_req(4'b1000);
        cyc(1);
        bus.tick_in = ~bus.tick_in;
        cyc(2);
        pulse_req(4'b0100);
        check("pass_floor", 32'(bus.floor), 2);
        check("pass_moving", 32'(bus.moving), 1);
        check("pass_pending", 32'(bus.pending), 32'hC);
        tick();
        check("pass_floor3", 32'(bus.floor), 3);
        check("pass_pend3", 32'(bus.pending), 32'h4);
        tick();
        tick();
        check("pass_back_dir", 32'(bus.dir_up), 0);
        tick();
        check("pass_serve_floor", 32'(bus.floor), 2);
        check("pass_serve_door", 32'(bus.door_open), 1);
        check("pass_serve_pend", 32'(bus.pending), 0);
        tick();
        tick();
        check("pass_idle", 32'(bus.hold), 1);

        // Reset mid-MOVE at floor 2.
        pulse_req(4'b0001);
        cyc(1);
        check("mid_moving", 32'(bus.moving), 1);
        check("mid_floor", 32'(bus.floor), 2);
        reset = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        cyc(1);
        reset = 1'b0;
        cyc(5);

`ifdef ELEVATOR_DOOR_HOLD_EN
        pulse_req(4'b0010);
        cyc(1);
        tick();
        check("dh_door", 32'(bus.door_open), 1);
        bus.door_hold = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("dh_held", 32'(bus.door_open), 1);
        check("dh_floor", 32'(bus.floor), 1);
        bus.door_hold = 1'b0;
        cyc(1);
        tick();
        check("dh_rel1", 32'(bus.door_open), 1);
        tick();
        check("dh_rel2", 32'(bus.door_open), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
